// File: rtl/muller_c_arbiter_if.sv
// Requester / C-element bundle for the shared Muller C-element sequencer.
// slave: arbiter side. master: requesters plus the element itself.
interface muller_c_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] gnt_o;
  logic [N_REQ-1:0] done_o;
  logic             c_a_o;
  logic             c_b_o;
  logic             c_q_i;
  logic             busy_o;
  logic             err_o;
  logic [2:0]       err_id_o;

  modport slave (
    input  req_i,
    input  c_q_i,
    output gnt_o,
    output done_o,
    output c_a_o,
    output c_b_o,
    output busy_o,
    output err_o,
    output err_id_o
  );

  modport master (
    output req_i,
    output c_q_i,
    input  gnt_o,
    input  done_o,
    input  c_a_o,
    input  c_b_o,
    input  busy_o,
    input  err_o,
    input  err_id_o
  );
endinterface

// File: rtl/muller_c_arbiter.sv
// Round-robin arbiter + 4-phase sequencer sharing one Muller C-element.
// Ports: wb_clk_i, wb_rst_ni (sync, active-low), bus (slave modport):
//   req_i/gnt_o/done_o per requester, c_a_o/c_b_o element inputs,
//   c_q_i element output (async), busy_o, err_o (sticky), err_id_o.
// Option: define MULLER_C_SKEW_EN to drive A and B with a 4-cycle skew
//   and flag an element that fires on a single input.
module muller_c_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 200
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  muller_c_arbiter_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = '1;
  localparam logic [IW-1:0] WIN_LAST =
    IW'(N_REQ - 1);
`ifdef MULLER_C_SKEW_EN
  localparam logic [TMO_W-1:0] SKEW_LAST =
    TMO_W'(3);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_RISE,
    S_FALL,
    S_DONE,
    S_ERR,
    S_RISE_A,
    S_FALL_B
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [2:0]       err_id_q, err_id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             c_a_q, c_a_d;
  logic             c_b_q, c_b_d;
  logic             s1_q, s2_q;
  logic             q_s;

  assign q_s = s2_q;

  // First set request at or after ptr, wrapping.
  function automatic logic [IW-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IW-1:0]    ptr
  );
    logic [IW-1:0] w;
    logic          found;
    int            j;
    w     = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[IW'(j)]) begin
        w     = IW'(j);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [N_REQ-1:0] oh(
    input logic [IW-1:0] i
  );
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    err_id_d = err_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.req_i) state_d = S_ARB;
      end
      S_ARB: begin
        if (|bus.req_i) begin
          win_d = rr_pick(bus.req_i, ptr_q);
          ptr_d = (win_d == WIN_LAST) ?
                  '0 : win_d + IW'(1);
`ifdef MULLER_C_SKEW_EN
          state_d = S_RISE_A;
`else
          state_d = S_RISE;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RISE: begin
        if (q_s) begin
`ifdef MULLER_C_SKEW_EN
          state_d = S_FALL_B;
`else
          state_d = S_FALL;
`endif
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ERR;
        end
      end
      S_FALL: begin
        if (!q_s) state_d = S_DONE;
        else if (cnt_q == TMO_LAST)
          state_d = S_ERR;
      end
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_ERR;
`ifdef MULLER_C_SKEW_EN
      // Only A is high: a real C-element must hold 0.
      S_RISE_A: begin
        if (q_s) state_d = S_ERR;
        else if (cnt_q == SKEW_LAST)
          state_d = S_RISE;
      end
      // Only B dropped: a real C-element must hold 1.
      S_FALL_B: begin
        if (!q_s) state_d = S_ERR;
        else if (cnt_q == SKEW_LAST)
          state_d = S_FALL;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERR && state_q != S_ERR)
      err_id_d = 3'(win_q);
  end

  // Phase counter: zero on any state change,
  // saturating count while a phase is waited on.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q &&
        state_q inside {S_RISE, S_FALL,
                        S_RISE_A, S_FALL_B})
      cnt_d = (cnt_q == TMO_MAX) ?
              cnt_q : cnt_q + TMO_W'(1);
  end

  // Element inputs and grant are registered
  // from the next state.
  always_comb begin
    c_a_d = state_d inside {S_RISE_A, S_RISE,
                            S_FALL_B};
    c_b_d = (state_d == S_RISE);
    gnt_d = '0;
    if (state_d inside {S_RISE_A, S_RISE,
                        S_FALL_B, S_FALL, S_DONE})
      gnt_d = oh(win_d);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      err_id_q <= '0;
      gnt_q    <= '0;
      c_a_q    <= 1'b0;
      c_b_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      err_id_q <= err_id_d;
      gnt_q    <= gnt_d;
      c_a_q    <= c_a_d;
      c_b_q    <= c_b_d;
      s1_q     <= bus.c_q_i;
      s2_q     <= s1_q;
    end
  end

  assign bus.gnt_o    = gnt_q;
  assign bus.done_o   = (state_q == S_DONE) ?
                        oh(win_q) : '0;
  assign bus.c_a_o    = c_a_q;
  assign bus.c_b_o    = c_b_q;
  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.err_o    = (state_q == S_ERR);
  assign bus.err_id_o = err_id_q;

endmodule

// File: tb/tb_muller_c_arbiter.sv
// Bench for muller_c_arbiter: C-element model,
// round-robin reference model, random + directed stimulus.
module tb_muller_c_arbiter;

  localparam int N   = 4;
  localparam int TMO = 200;
`ifdef MULLER_C_SKEW_EN
  localparam int LAT   = 17;
  localparam int EXTRA = 4;
  localparam logic [1:0] AB_RISE = 2'b10;
`else
  localparam int LAT   = 9;
  localparam int EXTRA = 0;
  localparam logic [1:0] AB_RISE = 2'b11;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   mptr = 0;
  int   elem_mode = 0;
  logic celem_q = 1'b0;

  always #5 clk = ~clk;

  muller_c_arbiter_if #(.N_REQ(N)) bus ();

  muller_c_arbiter #(
    .N_REQ  (N),
    .TMO_W  (8),
    .TMO_CYC(TMO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus)
  );

  // 0: true C-element (holds when inputs differ)
  // 1: stuck at 0
  // 2: broken, behaves as A|B
  always @(bus.c_a_o or bus.c_b_o)
    if (bus.c_a_o == bus.c_b_o) celem_q = bus.c_a_o;

  assign bus.c_q_i =
    (elem_mode == 0) ? celem_q :
    (elem_mode == 1) ? 1'b0 :
    (bus.c_a_o | bus.c_b_o);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic int rr_pick(
    input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (((r >> ((p + i) % N)) & 4'd1) != 0)
        return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [31:0] outs();
    return 32'({bus.gnt_o, bus.done_o,
                bus.c_a_o, bus.c_b_o,
                bus.busy_o, bus.err_o,
                bus.err_id_o});
  endfunction

  task automatic do_reset();
    bus.req_i = '1;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outs", outs(), 32'd0);
    end
    bus.req_i = '0;
    rst_n = 1'b1;
    mptr = 0;
  endtask

  // Wait for a grant and its done pulse.
  task automatic handshake(input int exp_w,
                           input bit drop,
                           input string tag);
    int k;
    k = 0;
    while (bus.gnt_o == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_gnt"}, 32'(bus.gnt_o),
        32'd1 << exp_w);
    if (drop) bus.req_i = '0;
    k = 0;
    while (bus.done_o == '0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, 32'(bus.done_o),
        32'd1 << exp_w);
    @(negedge clk);
    chk({tag, "_done_end"},
        32'({bus.gnt_o, bus.done_o}), 32'd0);
    mptr = (exp_w + 1) % N;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int first_g;
    logic [N-1:0] g_seen;
    logic [1:0]   ab_seen;
    logic [N-1:0] pat;
    int w;

    bus.req_i = '1;
    do_reset();

    // Single request: latency and grant.
    @(negedge clk);
    bus.req_i = 4'b0100;
    k = 0;
    first_g = 0;
    g_seen = '0;
    ab_seen = '0;
    while (bus.done_o == '0 && k < 60) begin
      @(negedge clk);
      k++;
      if (bus.gnt_o != '0 && first_g == 0) begin
        first_g = k + 1;
        g_seen = bus.gnt_o;
        ab_seen = {bus.c_a_o, bus.c_b_o};
      end
    end
    chk("single_gnt_cycle", first_g, 3);
    chk("single_gnt", 32'(g_seen), 32'h4);
    chk("single_rise_ab", 32'(ab_seen),
        32'(AB_RISE));
    chk("single_latency", k + 1, LAT);
    chk("single_done", 32'(bus.done_o), 32'h4);
    chk("single_err", 32'(bus.err_o), 32'd0);
    @(negedge clk);
    chk("single_done_end",
        32'({bus.gnt_o, bus.done_o}), 32'd0);
    bus.req_i = '0;

    // Round robin with all requests held.
    do_reset();
    @(negedge clk);
    bus.req_i = 4'b1111;
    for (int n = 0; n < 5; n++)
      handshake(rr_pick(4'b1111, mptr), 1'b0,
                "rr");
    bus.req_i = '0;
    repeat (3) @(negedge clk);
    chk("rr_idle_busy", 32'(bus.busy_o), 32'd0);

    // Random request patterns vs model.
    for (int n = 0; n < 40; n++) begin
      pat = 4'($urandom_range(0, 15));
      bus.req_i = pat;
      if (pat == '0) begin
        repeat (3) @(negedge clk);
        chk("rand_idle", 32'({bus.busy_o,
            bus.gnt_o}), 32'd0);
      end else begin
        w = rr_pick(pat, mptr);
        handshake(w, $urandom_range(0, 3) == 0,
                  "rand");
      end
    end
    bus.req_i = '0;
    repeat (2) @(negedge clk);

    // Reset during the falling phase.
    do_reset();
    @(negedge clk);
    bus.req_i = 4'b1111;
    k = 0;
    while (!(bus.c_a_o && bus.c_b_o) && k < 40) begin
      @(negedge clk);
      k++;
    end
    while (bus.c_b_o && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("midfall_reached",
        32'({bus.c_b_o, bus.gnt_o}), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midfall_rst", 32'({bus.c_a_o,
        bus.c_b_o, bus.done_o, bus.gnt_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    handshake(rr_pick(4'b1111, mptr), 1'b0,
              "after_rst");
    bus.req_i = '0;

    // Stuck element: timeout.
    do_reset();
    elem_mode = 1;
    @(negedge clk);
    bus.req_i = 4'b0010;
    k = 0;
    while (bus.gnt_o == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (!bus.err_o && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_cycles", k, TMO + EXTRA);
    chk("tmo_err_id", 32'(bus.err_id_o), 32'd1);
    chk("tmo_outs", 32'({bus.c_a_o, bus.c_b_o,
        bus.gnt_o, bus.busy_o}), 32'd1);
    bus.req_i = 4'b1111;
    repeat (5) @(negedge clk);
    chk("err_hold", 32'({bus.gnt_o, bus.busy_o,
        bus.err_o, bus.done_o}), 32'h30);
    elem_mode = 0;
    do_reset();
    chk("err_cleared", 32'(bus.err_o), 32'd0);

`ifdef MULLER_C_SKEW_EN
    // Element firing on A alone.
    elem_mode = 2;
    @(negedge clk);
    bus.req_i = 4'b1000;
    k = 0;
    while (bus.gnt_o == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (!bus.err_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("skew_err_cycles", k, 3);
    chk("skew_err_id", 32'(bus.err_id_o), 32'd3);
    chk("skew_outs", 32'({bus.c_a_o, bus.c_b_o,
        bus.gnt_o}), 32'd0);
    elem_mode = 0;
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
